// File: rtl/enable_prescaler.sv
// Programmable tick generator: emits one-cycle enable pulses every div+1 clocks,
// continuously or as a burst of N pulses, with a done pulse on the final one.
module enable_prescaler #(
   parameter int WIDTH       = 8,
   parameter int DEFAULT_DIV = 3
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] div_value_i,
   input  logic             div_load_i,
   input  logic [3:0]       burst_len_i,
   input  logic             start_i,
   input  logic             stop_i,
   output logic             enable_o,
   output logic             done_o,
   output logic             busy_o
);

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] div_q, div_d;
   logic [WIDTH-1:0] pre_cnt_q, pre_cnt_d;
   logic [3:0]       left_q, left_d;
   logic             cont_q, cont_d;
   logic             enable_q, enable_d;
   logic             done_q, done_d;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= IDLE;
         div_q     <= WIDTH'(DEFAULT_DIV);
         pre_cnt_q <= '0;
         left_q    <= '0;
         cont_q    <= 1'b0;
         enable_q  <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         div_q     <= div_d;
         pre_cnt_q <= pre_cnt_d;
         left_q    <= left_d;
         cont_q    <= cont_d;
         enable_q  <= enable_d;
         done_q    <= done_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      div_d     = div_q;
      pre_cnt_d = pre_cnt_q;
      left_d    = left_q;
      cont_d    = cont_q;
      enable_d  = 1'b0;
      done_d    = 1'b0;
      case (state_q)
         IDLE: begin
            // Load and start may coincide; the freshly loaded divisor then governs the run.
            if (div_load_i) begin
               div_d = div_value_i;
            end
            if (start_i && !stop_i) begin
               state_d   = RUN;
               pre_cnt_d = '0;
               left_d    = burst_len_i;
               cont_d    = (burst_len_i == 4'd0);
            end
         end
         RUN: begin
            if (stop_i) begin
               state_d   = IDLE;
               pre_cnt_d = '0;
            end else if (pre_cnt_q == div_q) begin
               enable_d  = 1'b1;
               pre_cnt_d = '0;
               if (!cont_q) begin
                  left_d = left_q - 4'd1;
                  if (left_q == 4'd1) begin
                     done_d  = 1'b1;
                     state_d = IDLE;
                  end
               end
            end else begin
               pre_cnt_d = pre_cnt_q + WIDTH'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign enable_o = enable_q;
   assign done_o   = done_q;
   assign busy_o   = (state_q == RUN);

endmodule

// File: doc/enable_prescaler.md
# enable_prescaler

Programmable tick generator that drives the `enable` input of the 4-bit `counter` stage. It emits single-cycle `enable` pulses every `div+1` clocks, either continuously or as a burst of exactly N pulses, so the downstream counter advances by a known amount. A small run/stop FSM, a divisor register and a burst counter make up the block.

## Interface
- `WIDTH`, 8: width of the divisor register and prescale counter.
- `DEFAULT_DIV`, 3: divisor value loaded at reset (period = `DEFAULT_DIV`+1).
- `clock` input 1: system clock; all logic on posedge.
- `reset` input 1: synchronous, active-high reset.
- `div_value` input WIDTH: new divisor, captured when `div_load`=1.
- `div_load` input 1: load strobe; honoured only in IDLE.
- `burst_len` input 4: pulses per run, captured on start; 0 = continuous.
- `start` input 1: begin run; honoured only in IDLE.
- `stop` input 1: abort run; returns to IDLE.
- `enable` output 1: registered tick pulse to counter's `enable`.
- `done` output 1: registered one-cycle pulse, coincident with final burst pulse.
- `busy` output 1: high whenever state is RUN.

## Operation
- States: IDLE, RUN. `busy` = (state==RUN), derived from the state register.
- Registers: `div_reg`[WIDTH], `pre_cnt`[WIDTH], `left`[4], `cont` flag.
- Reset (priority 1): state=IDLE, `div_reg`=DEFAULT_DIV, `pre_cnt`=0, `left`=0, `enable`=0, `done`=0, `busy`=0.
- `stop` (priority 2): in RUN → IDLE, `pre_cnt`=0, `enable`=0, `done`=0; in IDLE no effect. `stop` also blocks a same-edge `start`.
- IDLE: `div_load`=1 → `div_reg`=`div_value`. `start`=1 → RUN, `pre_cnt`=0, `left`=`burst_len`, `cont`=(`burst_len`==0). With `div_load` and `start` on the same edge, the new `div_value` governs the run.
- RUN, each edge:
  - `pre_cnt`==`div_reg` → `enable`<=1, `pre_cnt`<=0. If !`cont`: `left`<=`left`-1; if `left`==1 also `done`<=1, state<=IDLE.
  - Otherwise `enable`<=0, `done`<=0, `pre_cnt`<=`pre_cnt`+1.
- `div_load` and `start` while in RUN are ignored; `div_reg` is unchanged mid-run.
- `div_value`=0 is legal: `enable` high on every cycle of the run.
- `done` and `enable` are never high outside the cycle after a generating edge; both clear on the next edge.

## Timing
- `start` sampled at edge E0 → `busy` high after E0; first `enable` high in the cycle after edge E0+`div_reg`+1.
- Pulse period: `div_reg`+1 cycles; pulse width: exactly 1 cycle.
- Burst of N: last `enable` and `done` high together in the cycle after edge E0+N·(`div_reg`+1); `busy` low in that same cycle. A new `start` is accepted at the next edge.
- `stop` at edge Es: `enable`, `busy` low after Es. If Es would have generated a pulse, `stop` wins: no pulse and no `done`.
- Reset mid-run: same as power-on reset; `div_reg` reverts to DEFAULT_DIV.
- Counter stage latency: counter updates on the edge after `enable` is high, so after a burst of N the counter has advanced by N mod 16.

## Test plan
- Reset, then `start` with `burst_len`=0 and default div 3 → `enable` high in cycles after E0+4, +8, +12…; `busy`=1; `done` never high.
- `div_load` value 0, then `start` with `burst_len`=5 → `enable` high 5 consecutive cycles, `done` high with the 5th, `busy` low in that cycle; downstream counter reads 5.
- Div 2, `burst_len`=3 → `enable` after E0+3, +6, +9; `done` coincident with the 3rd; a second `start` issued immediately yields 3 more pulses (counter reads 6).
- Div 3 continuous, `stop` on the edge a pulse is due → no `enable`, `busy` low next cycle; simultaneous `start`+`stop` in IDLE → stays IDLE.
- During RUN, pulse `div_load` with value 7 and `start` → period stays 4 and the burst is not restarted; after return to IDLE, load 7 → period 8.
- Reset asserted mid-burst → all outputs 0 next cycle; `div_reg` back to 3, verified by the next run's 4-cycle period.
